seg_status_mux: RTL and testbench
=================================

Name: seg_status_mux

Overview:
- Generalised 7-segment status encoder.
- Takes NUM_SRC independent status sources, each with its own active flag and DIGITS-hex-digit code, and drives the display digits.
- Multiple pending sources are shown in round-robin order, each for a guaranteed minimum hold time, so single-cycle events remain visible.
- Selected sources latch (sticky) until software/button clear. Sits between the status producers (memory controller, CPU fault logic) and the 7-segment driver.

Parameters:
- NUM_SRC, 4, number of status sources (>= 2).
- DIGITS, 3, hex digits per code; code/output width CW = 4*DIGITS.
- HOLD_CYCLES, 50000000, minimum clk cycles each selected code is displayed (>= 1).
- DEFAULT_CODE, 12'h100, CW-bit code shown when nothing is pending.
- STICKY_MASK, {NUM_SRC{1'b0}}, bit i = 1 makes source i sticky.
- Local parameter SRC_W = max(1, ceil(log2(NUM_SRC))).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- status_active  input  NUM_SRC  bit i high = source i currently asserting its code.
- status_codes  input  NUM_SRC*CW  packed codes; source i occupies bits [i*CW +: CW].
- clear  input  1  single-cycle pulse, clears all sticky latches.
- seg_digits  output  CW  registered code to display.
- cur_src  output  SRC_W  index of the source being shown (0 when idle).
- any_pending  output  1  registered OR of all pending bits.

Behaviour:
- All state is in the clk domain. rst asynchronously forces:
  - seg_digits = DEFAULT_CODE
  - cur_src = 0
  - any_pending = 0
  - sticky latches = 0
  - hold counter = 0
  - state = IDLE
- Sticky latch i, only where STICKY_MASK[i] = 1:
  - set on any cycle with status_active[i] = 1;
  - cleared by clear;
  - if set and clear occur in the same cycle, set wins.
  - Non-sticky bits have no latch.
- pending[i] = status_active[i] | latch[i]. pending uses the latch value before this cycle's update, so a pulse counts in the cycle it occurs.
- any_pending <= |pending each cycle, giving 1-cycle latency.
- State IDLE:
  - seg_digits holds DEFAULT_CODE.
  - If any pending bit is set, select the lowest pending index k.
  - On the next edge: seg_digits <= code k (snapshot), cur_src <= k, counter <= HOLD_CYCLES-1, state <= SHOW.
  - Pending-to-display latency is 1 cycle.
- State SHOW:
  - seg_digits is frozen at the snapshot. Later changes to code k, or k deasserting, do not alter the display.
  - counter decrements each cycle while nonzero.
- When counter == 0 in SHOW, scan for the next pending index after cur_src, wrapping modulo NUM_SRC. cur_src itself is the last candidate.
  - If found at j: snapshot code j, cur_src <= j, counter <= HOLD_CYCLES-1, stay in SHOW. This also covers j == cur_src, which re-snapshots the same source and restarts the hold.
  - If none pending: seg_digits <= DEFAULT_CODE, cur_src <= 0, state <= IDLE.
- Resulting display durations:
  - Each code is shown for exactly HOLD_CYCLES cycles per turn.
  - With HOLD_CYCLES = 1, a new selection is made every cycle.
- No preemption: a newly pending lower-index source waits for the current hold to expire.
- clear while a sticky code is displayed does not cut the hold short. The code stays until the counter expires; then it is dropped if not otherwise pending.
- Reset asserted mid-SHOW returns to the reset values immediately. No pending state survives reset.
- Counter width is ceil(log2(HOLD_CYCLES)) bits, minimum 1. No arithmetic wraps beyond HOLD_CYCLES-1.

Test Plan:
All scenarios use NUM_SRC=4, DIGITS=3, HOLD_CYCLES=4, DEFAULT_CODE=12'h100, STICKY_MASK=4'b0010, and codes 0x500/0x501/0x502/0x503 for sources 0-3.
1. Reset and idle: assert rst asynchronously mid-cycle -> seg_digits=0x100, cur_src=0, any_pending=0 immediately. They stay so with status_active=0.
2. Single held source: status_active=4'b0001 from cycle 0 -> seg_digits=0x500 from cycle 1 onward, continuously. The hold restarts every 4 cycles and cur_src stays 0.
3. Round robin: status_active=4'b0101 held -> 0x500 for cycles 1-4, 0x502 for 5-8, 0x500 for 9-12. cur_src alternates 0/2.
4. Sticky and clear: 1-cycle pulse on bit1 -> 0x501 displayed indefinitely after the pulse, any_pending=1. Pulse clear at an arbitrary cycle -> 0x501 persists until the current hold ends, then 0x100 and any_pending=0. clear coincident with a bit1 pulse -> latch remains set.
5. Non-sticky glitch and snapshot: 1-cycle pulse on bit3 with code 0x503, code changed to 0x5FF the following cycle -> 0x503 shown for exactly 4 cycles, then 0x100.
6. No preemption and reset mid-show: bit2 held, bit0 raised 2 cycles into the hold -> 0x502 completes its 4 cycles, then 0x500. Asserting rst during the 0x500 hold -> 0x100 immediately, and only re-pending sources reappear after release.

Source files
------------

// File: rtl/seg_status_mux.sv
// Status-to-7-segment encoder: round-robin display of pending status codes,
// each held for HOLD_CYCLES clocks, with optional sticky latching per source.
// Ports: clk/rst (async active-high), status_active/status_codes in, clear in,
//        seg_digits/cur_src/any_pending registered outputs.
module seg_status_mux #(
    parameter int                   NUM_SRC      = 4,
    parameter int                   DIGITS       = 3,
    parameter int                   HOLD_CYCLES  = 50000000,
    parameter logic [4*DIGITS-1:0]  DEFAULT_CODE = 12'h100,
    parameter logic [NUM_SRC-1:0]   STICKY_MASK  = '0,
    localparam int                  CW           = 4 * DIGITS,
    localparam int                  SRC_W        = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      status_active,
    input  logic [NUM_SRC*CW-1:0]   status_codes,
    input  logic                    clear,
    output logic [CW-1:0]           seg_digits,
    output logic [SRC_W-1:0]        cur_src,
    output logic                    any_pending
);

    localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [NUM_SRC-1:0]  latch, latch_nxt;
    logic [NUM_SRC-1:0]  pending;
    logic [CW-1:0]       seg_nxt;
    logic [SRC_W-1:0]    src_nxt;

    logic                low_found;
    logic [SRC_W-1:0]    low_idx;
    logic                rr_found;
    logic [SRC_W-1:0]    rr_idx;
    logic [SRC_W-1:0]    probe;
    logic [SRC_W-1:0]    sel_idx;
    logic [CW-1:0]       sel_code;

    // Pending uses the latch value from before this edge, so a one-cycle
    // pulse is visible in the same cycle it arrives. Set beats clear.
    always_comb begin
        pending   = status_active | (latch & STICKY_MASK);
        latch_nxt = STICKY_MASK & (status_active | (latch & ~{NUM_SRC{clear}}));
    end

    // Lowest pending index, used when leaving IDLE.
    always_comb begin
        low_found = |pending;
        low_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) low_idx = SRC_W'(i);
        end
    end

    // Next pending index after cur_src, wrapping; cur_src itself is checked
    // last. Walk offsets from far to near so the nearest hit wins.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        probe    = '0;
        for (int off = NUM_SRC; off >= 1; off--) begin
            probe = SRC_W'((int'(cur_src) + off) % NUM_SRC);
            if (pending[probe]) begin
                rr_found = 1'b1;
                rr_idx   = probe;
            end
        end
    end

    always_comb begin
        sel_idx  = (state == IDLE) ? low_idx : rr_idx;
        sel_code = status_codes[int'(sel_idx) * CW +: CW];
    end

    always_comb begin
        state_nxt = state;
        seg_nxt   = seg_digits;
        src_nxt   = cur_src;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (low_found) begin
                    state_nxt = SHOW;
                    seg_nxt   = sel_code;
                    src_nxt   = sel_idx;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
            SHOW: begin
                // Display stays frozen on the snapshot until the hold expires;
                // no preemption by newly pending sources.
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (rr_found) begin
                    seg_nxt = sel_code;
                    src_nxt = sel_idx;
                    cnt_nxt = HOLD_LOAD;
                end else begin
                    state_nxt = IDLE;
                    seg_nxt   = DEFAULT_CODE;
                    src_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                seg_nxt   = DEFAULT_CODE;
                src_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            latch       <= '0;
            seg_digits  <= DEFAULT_CODE;
            cur_src     <= '0;
            any_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            latch       <= latch_nxt;
            seg_digits  <= seg_nxt;
            cur_src     <= src_nxt;
            any_pending <= |pending;
        end
    end

endmodule

// File: tb/tb_seg_status_mux.sv
module tb_seg_status_mux;

    localparam int          NS    = 4;
    localparam int          HOLD  = 4;
    localparam logic [11:0] DEF   = 12'h100;
    localparam logic [3:0]  STK   = 4'b0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  status_active = '0;
    logic [47:0] status_codes;
    logic        clear = 1'b0;
    logic [11:0] seg_digits;
    logic [1:0]  cur_src;
    logic        any_pending;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_status_mux #(
        .NUM_SRC(NS), .DIGITS(3), .HOLD_CYCLES(HOLD),
        .DEFAULT_CODE(DEF), .STICKY_MASK(STK)
    ) dut (
        .clk(clk), .rst(rst), .status_active(status_active),
        .status_codes(status_codes), .clear(clear),
        .seg_digits(seg_digits), .cur_src(cur_src), .any_pending(any_pending)
    );

    typedef struct packed {
        logic [11:0] seg;
        logic [1:0]  src;
        logic        any;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: tracks which source is on display and how many cycles
    // it has been shown so far; a turn ends after HOLD displayed cycles.
    bit          m_show;
    int          m_src;
    int          m_elapsed;
    logic [11:0] m_seg;
    logic [3:0]  m_latch;
    bit          m_any;

    always @(posedge clk) begin
        logic [3:0] pend;
        bit found;
        int j;
        if (rst) begin
            m_show = 0; m_src = 0; m_elapsed = 0; m_seg = DEF; m_latch = '0; m_any = 0;
        end else begin
            pend    = status_active | (m_latch & STK);
            m_latch = STK & (status_active | (clear ? 4'b0000 : m_latch));
            m_any   = (pend != 4'b0000);
            if (!m_show) begin
                found = 0;
                for (int k = 0; k < NS; k++) begin
                    if (!found && pend[k]) begin
                        found = 1; m_src = k;
                    end
                end
                if (found) begin
                    m_show = 1; m_elapsed = 1; m_seg = status_codes[m_src*12 +: 12];
                end
            end else if (m_elapsed < HOLD) begin
                m_elapsed++;
            end else begin
                found = 0;
                for (int off = 1; off <= NS; off++) begin
                    j = (m_src + off) % NS;
                    if (!found && pend[j]) begin
                        found = 1; m_src = j;
                    end
                end
                if (found) begin
                    m_elapsed = 1; m_seg = status_codes[m_src*12 +: 12];
                end else begin
                    m_show = 0; m_src = 0; m_seg = DEF;
                end
            end
        end
        exp_q.push_back('{seg: m_seg, src: 2'(m_src), any: m_any});
    end

    // Monitor: outputs are registered, so each edge presents a new sample.
    always @(posedge clk) begin
        exp_t e;
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (seg_digits !== e.seg || cur_src !== e.src || any_pending !== e.any) begin
                errors++;
                $display("FAIL scoreboard t=%0t got seg=%h src=%0d any=%b exp seg=%h src=%0d any=%b",
                         $time, seg_digits, cur_src, any_pending, e.seg, e.src, e.any);
            end
        end
    end

    task automatic check(input string name, input logic [11:0] seg, input logic [1:0] src,
                         input logic any);
        checks++;
        if (seg_digits !== seg || cur_src !== src || any_pending !== any) begin
            errors++;
            $display("FAIL %s t=%0t got seg=%h src=%0d any=%b exp seg=%h src=%0d any=%b",
                     name, $time, seg_digits, cur_src, any_pending, seg, src, any);
        end
    endtask

    task automatic check_seg(input string name, input logic [11:0] seg);
        checks++;
        if (seg_digits !== seg) begin
            errors++;
            $display("FAIL %s t=%0t got seg=%h exp seg=%h", name, $time, seg_digits, seg);
        end
    endtask

    task automatic set_std_codes();
        status_codes = {12'h503, 12'h502, 12'h501, 12'h500};
    endtask

    // Assert reset asynchronously mid-cycle and check it takes effect at once.
    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check(name, DEF, 2'd0, 1'b0);
        status_active = '0;
        clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        set_std_codes();
        wait_cycles(2);
        rst = 1'b0;

        // 1: reset and idle
        wait_cycles(3);
        async_reset("reset_async");
        wait_cycles(5);
        check("reset_idle", DEF, 2'd0, 1'b0);

        // 2: single held source
        status_active = 4'b0001;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check("single_held", 12'h500, 2'd0, 1'b1);
        end
        async_reset("reset_s2");

        // 3: round robin between sources 0 and 2
        status_active = 4'b0101;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 4 || c >= 9) check("round_robin", 12'h500, 2'd0, 1'b1);
            else                  check("round_robin", 12'h502, 2'd2, 1'b1);
        end
        async_reset("reset_s3");

        // 4: sticky latch and clear
        status_active = 4'b0010;
        @(negedge clk);
        status_active = 4'b0000;
        wait_cycles(10);
        check("sticky_hold", 12'h501, 2'd1, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_seg("sticky_after_clear", 12'h501);
        wait_cycles(5);
        check("sticky_cleared", DEF, 2'd0, 1'b0);
        status_active = 4'b0010;
        clear = 1'b1;
        @(negedge clk);
        status_active = 4'b0000;
        clear = 1'b0;
        wait_cycles(10);
        check("set_beats_clear", 12'h501, 2'd1, 1'b1);
        async_reset("reset_s4");

        // 5: non-sticky glitch, snapshot survives code change
        status_active = 4'b1000;
        @(negedge clk);
        status_active = 4'b0000;
        status_codes[36 +: 12] = 12'h5FF;
        check_seg("glitch_c1", 12'h503);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            check_seg("glitch_snapshot", 12'h503);
        end
        @(negedge clk);
        check("glitch_done", DEF, 2'd0, 1'b0);
        set_std_codes();
        async_reset("reset_s5");

        // 6: no preemption, then reset mid-show
        status_active = 4'b0100;
        wait_cycles(2);
        status_active = 4'b0101;
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 4) check("no_preempt", 12'h502, 2'd2, 1'b1);
            else        check("no_preempt", 12'h500, 2'd0, 1'b1);
        end
        async_reset("reset_mid_show");
        wait_cycles(3);
        check("after_reset_idle", DEF, 2'd0, 1'b0);
        status_active = 4'b0001;
        @(negedge clk);
        check("repend_after_reset", 12'h500, 2'd0, 1'b1);
        status_active = 4'b0000;
        wait_cycles(6);

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            status_active = 4'($urandom) & 4'($urandom) & 4'($urandom);
            clear = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0)
                status_codes[$urandom_range(0, 3)*12 +: 12] = 12'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        status_active = '0;
        clear = 1'b0;
        wait_cycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
